// File: rtl/fusion_sequencer.sv
// fusion_sequencer: computes an 8x8 product (each operand signed or unsigned)
// by issuing four 4x4 sub-products to one external fusion multiplier with a
// 2-cycle product latency, then shifting and summing them into a 16-bit result.
// Optional build macro FUSION_SEQ_4B_MODE_EN adds a 'mode' input. With mode=1
// the block does a single 4x4 pass on the low nibbles.
//
// Handshakes use valid/ready. A transfer happens on a rising clk edge where
// valid and ready are both 1. In this design in_ready is 1 only in IDLE, and
// out_valid is 1 only in DONE. While out_valid is 1, result stays stable until
// the transfer.
module fusion_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic        s_a,
   input  logic        s_b,
`ifdef FUSION_SEQ_4B_MODE_EN
   input  logic        mode,
`endif
   output logic [3:0]  fu_in,
   output logic [3:0]  fu_weight,
   output logic        fu_s_in,
   output logic        fu_s_weight,
   input  logic [7:0]  fu_psum,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic        s_a_q, s_a_d, s_b_q, s_b_d;
   logic        four_b_q, four_b_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] result_q, result_d;

   logic        accept;
   logic        run_last;
   logic [2:0]  sub_idx;
   logic        psum_signed;
   logic [15:0] psum_ext;
   logic [15:0] psum_term;
   logic [15:0] acc_sum;
   logic        four_b_in;

`ifdef FUSION_SEQ_4B_MODE_EN
   assign four_b_in = mode;
`else
   assign four_b_in = 1'b0;
`endif

   assign accept   = (state_q == ST_IDLE) && in_valid;
   // The last RUN cycle is the one that samples the final product.
   assign run_last = four_b_q ? (cnt_q == 3'd2) : (cnt_q == 3'd5);
   // The product arriving now was issued two cycles earlier.
   assign sub_idx  = cnt_q - 3'd2;

   // Pick the extension and alignment for the product arriving this cycle.
   always_comb begin
      psum_signed = 1'b0;
      psum_term   = '0;
      if (four_b_q) begin
         psum_signed = s_a_q | s_b_q;
      end else begin
         case (sub_idx[1:0])
            2'd0:    psum_signed = 1'b0;
            2'd1:    psum_signed = s_b_q;
            2'd2:    psum_signed = s_a_q;
            default: psum_signed = s_a_q | s_b_q;
         endcase
      end
      psum_ext = psum_signed ? {{8{fu_psum[7]}}, fu_psum} : {8'h00, fu_psum};
      if (four_b_q) begin
         psum_term = psum_ext;
      end else begin
         case (sub_idx[1:0])
            2'd0:    psum_term = psum_ext;
            2'd1,
            2'd2:    psum_term = psum_ext << 4;
            default: psum_term = psum_ext << 8;
         endcase
      end
      acc_sum = acc_q + psum_term;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (run_last)  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and the operand pairs sent to the multiplier.
   always_comb begin
      in_ready    = (state_q == ST_IDLE) && !rst;
      out_valid   = (state_q == ST_DONE);
      dbg_state   = state_q;
      fu_in       = '0;
      fu_weight   = '0;
      fu_s_in     = 1'b0;
      fu_s_weight = 1'b0;
      if (state_q == ST_RUN && !cnt_q[2]) begin
         if (four_b_q) begin
            if (cnt_q == 3'd0) begin
               fu_in       = a_q[3:0];
               fu_weight   = b_q[3:0];
               fu_s_in     = s_a_q;
               fu_s_weight = s_b_q;
            end
         end else begin
            case (cnt_q[1:0])
               2'd0: begin
                  fu_in     = a_q[3:0];
                  fu_weight = b_q[3:0];
               end
               2'd1: begin
                  fu_in       = a_q[3:0];
                  fu_weight   = b_q[7:4];
                  fu_s_weight = s_b_q;
               end
               2'd2: begin
                  fu_in     = a_q[7:4];
                  fu_weight = b_q[3:0];
                  fu_s_in   = s_a_q;
               end
               default: begin
                  fu_in       = a_q[7:4];
                  fu_weight   = b_q[7:4];
                  fu_s_in     = s_a_q;
                  fu_s_weight = s_b_q;
               end
            endcase
         end
      end
   end

   // Operand capture, step counter, accumulation and result update.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      s_a_d    = s_a_q;
      s_b_d    = s_b_q;
      four_b_d = four_b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      if (accept) begin
         a_d      = a;
         b_d      = b;
         s_a_d    = s_a;
         s_b_d    = s_b;
         four_b_d = four_b_in;
         cnt_d    = 3'd0;
         acc_d    = '0;
      end else if (state_q == ST_RUN) begin
         cnt_d = run_last ? 3'd0 : cnt_q + 3'd1;
         if (cnt_q >= 3'd2) begin
            acc_d = acc_sum;
            if (run_last) begin
               result_d = acc_sum;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         s_a_q    <= 1'b0;
         s_b_q    <= 1'b0;
         four_b_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         s_a_q    <= s_a_d;
         s_b_q    <= s_b_d;
         four_b_q <= four_b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_fusion_sequencer.sv
// Bench for fusion_sequencer. It contains a 2-stage model of the external 4x4
// fusion multiplier, a reference model based on integer multiplication,
// directed corner cases and randomized operations.
module tb_fusion_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        s_a, s_b;
   logic        mode;
   logic [3:0]  fu_in, fu_weight;
   logic        fu_s_in, fu_s_weight;
   logic [7:0]  fu_psum;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [1:0]  dbg_state;

   logic [7:0]  mul_now, mul_p1;
   logic [15:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   fusion_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .s_a         (s_a),
      .s_b         (s_b),
`ifdef FUSION_SEQ_4B_MODE_EN
      .mode        (mode),
`endif
      .fu_in       (fu_in),
      .fu_weight   (fu_weight),
      .fu_s_in     (fu_s_in),
      .fu_s_weight (fu_s_weight),
      .fu_psum     (fu_psum),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .dbg_state   (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Value of a nibble as signed or unsigned.
   function automatic int nib_val(input logic [3:0] n, input logic sg);
      if (sg) return int'($signed(n));
      return int'(n);
   endfunction

   // Value of a byte as signed or unsigned.
   function automatic int byte_val(input logic [7:0] n, input logic sg);
      if (sg) return int'($signed(n));
      return int'(n);
   endfunction

   // Reference product, computed as an integer and truncated to 16 bits.
   function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                            input logic sx, input logic sy, input logic m);
      int p;
      if (m) p = nib_val(x[3:0], sx) * nib_val(y[3:0], sy);
      else   p = byte_val(x, sx) * byte_val(y, sy);
      return 16'(p);
   endfunction

   // External multiplier: the product appears two clock edges after its operands.
   assign mul_now = 8'(nib_val(fu_in, fu_s_in) * nib_val(fu_weight, fu_s_weight));
   always @(posedge clk) begin
      mul_p1  <= mul_now;
      fu_psum <= mul_p1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accept one operation, track it cycle by cycle, hold DONE for 'hold' cycles, then release.
   task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic sx,
                        input logic sy, input logic m, input int hold,
                        input logic [15:0] exp_res);
      logic [9:0]  exp_fu[0:7];
      logic [15:0] exp_r;
      int          lat;
      int          exp_lat;
      exp_lat = m ? 4 : 7;
      for (int i = 0; i < 8; i++) exp_fu[i] = '0;
      if (m) begin
         exp_fu[1] = {sx, sy, x[3:0], y[3:0]};
      end else begin
         exp_fu[1] = {1'b0, 1'b0, x[3:0], y[3:0]};
         exp_fu[2] = {1'b0, sy,   x[3:0], y[7:4]};
         exp_fu[3] = {sx,   1'b0, x[7:4], y[3:0]};
         exp_fu[4] = {sx,   sy,   x[7:4], y[7:4]};
      end
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      check("fu_idle", 32'({fu_s_in, fu_s_weight, fu_in, fu_weight}), 32'd0);
      a = x; b = y; s_a = sx; s_b = sy; mode = m; in_valid = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(exp_res);
      lat = 0;
      do begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         a = 8'($urandom); b = 8'($urandom);
         s_a = 1'($urandom); s_b = 1'($urandom); mode = 1'($urandom);
         @(negedge clk);
         lat++;
         if (!out_valid) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            check("fu_run", 32'({fu_s_in, fu_s_weight, fu_in, fu_weight}), 32'(exp_fu[lat & 7]));
         end
      end while (!out_valid && lat < 20);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      if (!out_valid) begin
         void'(exp_q.pop_front());
         return;
      end
      exp_r = exp_q.pop_front();
      check("result", 32'(result), 32'(exp_r));
      check("fu_done", 32'({fu_s_in, fu_s_weight, fu_in, fu_weight}), 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2 == 0);
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(result), 32'(exp_r));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("released_valid", 32'(out_valid), 32'd0);
      check("released_in_ready", 32'(in_ready), 32'd1);
      check("result_kept", 32'(result), 32'(exp_r));
   endtask

   // Accept an operation and assert rst in its RUN cnt=3 cycle.
   task automatic abort_op(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      a = x; b = y; s_a = 1'b0; s_b = 1'b0; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_fu", 32'({fu_s_in, fu_s_weight, fu_in, fu_weight}), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_abort_in_ready", 32'(in_ready), 32'd1);
      check("post_abort_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] rx, ry;
      logic       rsx, rsy, rm;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; s_a = 1'b0; s_b = 1'b0; mode = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_fu", 32'({fu_s_in, fu_s_weight, fu_in, fu_weight}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 16'hFE01);
      do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 0, 16'h4000);
      do_op(8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1, 16'hC080);
      do_op(8'hFF, 8'hC8, 1'b1, 1'b0, 1'b0, 0, 16'hFF38);
      do_op(8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 2, 16'h8080);
      do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 5, 16'hFE01);

      abort_op(8'hAB, 8'hCD);
      do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 0, 16'h03A8);

`ifdef FUSION_SEQ_4B_MODE_EN
      do_op(8'h0F, 8'h07, 1'b1, 1'b0, 1'b1, 0, 16'hFFF9);
`endif

      for (int n = 0; n < 40; n++) begin
         rx  = 8'($urandom);
         ry  = 8'($urandom);
         rsx = 1'($urandom);
         rsy = 1'($urandom);
`ifdef FUSION_SEQ_4B_MODE_EN
         rm  = 1'($urandom_range(0, 3) == 0);
`else
         rm  = 1'b0;
`endif
         do_op(rx, ry, rsx, rsy, rm, $urandom_range(0, 3), ref_prod(rx, ry, rsx, rsy, rm));
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fusion_sequencer.md
FUSION_SEQUENCER -- requirements
Module: fusion_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-004 SHALL have ports a and b (input, 8 each): multiplicand and multiplier.
REQ-005 SHALL have ports s_a and s_b (input, 1 each): 1 = operand is two's-complement signed, 0 = unsigned.
REQ-006 SHALL have ports fu_in, fu_weight (output, 4 each) and fu_s_in, fu_s_weight (output, 1 each): drive one external 4x4 fusion multiplier.
REQ-007 SHALL have port fu_psum, input, 8: multiplier product, valid 2 cycles after its operands are driven.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and result (output, 16): product handshake.

Function
REQ-009 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-010 SHALL assert in_ready only in IDLE; in_valid&in_ready at an edge latches a, b, s_a, s_b, clears accumulator, enters RUN with cnt=0.
REQ-011 SHALL in RUN increment 3-bit cnt each cycle; after the cnt=5 cycle, enter DONE.
REQ-012 SHALL in RUN with cnt=k (k<4) drive sub-product k from registers: 0 = Al x Bl (0,0); 1 = Al x Bh (0,s_b); 2 = Ah x Bl (s_a,0); 3 = Ah x Bh (s_a,s_b); fields are (fu_s_in, fu_s_weight); Al/Bl = low nibbles, Ah/Bh = high nibbles.
REQ-013 SHALL drive fu_in, fu_weight, fu_s_in, fu_s_weight to 0 in IDLE, DONE, and RUN with cnt>=4.
REQ-014 SHALL in RUN with cnt=k (k>=2) add sub-product k-2 into the 16-bit accumulator: fu_psum sign-extended if either of its sign flags is 1, else zero-extended; shifted left 0, 4, 4, 8 for sub-products 0..3.
REQ-015 SHALL wrap accumulation modulo 2^16; result equals the exact 16-bit product for all sign combinations.
REQ-016 SHALL hold out_valid=1 and result stable in DONE until out_ready=1; the DONE+out_ready edge returns to IDLE.
REQ-017 SHALL keep out_valid asserted first in the 7th cycle after the accept edge; max throughput 1 op per 8 cycles.
REQ-018 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-019 SHALL keep result at its last value outside DONE; sample fu_psum only in RUN cnt 2..5.

Reset
REQ-020 SHALL on rst force IDLE, cnt=0, accumulator/result=0, out_valid=0, fu_* outputs=0, in_ready=1 after release.
REQ-021 SHALL on rst during RUN or DONE abort the operation without producing out_valid; the first post-reset operation SHALL be correct despite stale products inside the multiplier.

Configuration
REQ-022 SHALL, with FUSION_SEQ_4B_MODE_EN defined, add input mode (1 bit, latched at accept); mode=1: one pass Al x Bl with flags (s_a,s_b), RUN cnt 0..2 only, result = fu_psum sign-extended if s_a|s_b else zero-extended, out_valid in 4th cycle after accept.
REQ-023 SHALL, without FUSION_SEQ_4B_MODE_EN, omit port mode and always perform the 8x8 four-pass sequence.

Verification
REQ-024 SHALL test a=0xFF, b=0xFF, s_a=0, s_b=0 -> result=0xFE01, out_valid 7th cycle after accept.
REQ-025 SHALL test a=0x80, b=0x80, s_a=1, s_b=1 -> result=0x4000; a=0x80, b=0x7F signed -> 0xC080.
REQ-026 SHALL test a=0xFF signed, b=0xC8 unsigned -> result=0xFF38 (-200); a=0x80 signed, b=0xFF unsigned -> 0x8080.
REQ-027 SHALL test out_ready low 5 cycles in DONE -> out_valid and result held, in_ready=0; in_valid pulsed meanwhile is not accepted.
REQ-028 SHALL test rst asserted at RUN cnt=3 -> all outputs 0 immediately; next op 0x12 x 0x34 unsigned -> 0x03A8.
REQ-029 SHALL test (macro defined) mode=1, a=0x0F, b=0x07, s_a=1, s_b=0 -> result=0xFFF9, out_valid 4th cycle after accept.
